// File: rtl/field_pow2_pkg.sv
// Shared types and helpers for the power-of-two field multiplier.
// Field shape comes from F_NBITS / F_I; negation is enabled by FIELD_MUL_POW2_NEG_EN.
`ifndef F_NBITS
`define F_NBITS 8
`endif
`ifndef F_I
`define F_I 5
`endif

package field_pow2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        REDUCE
    } state_t;

    localparam logic [`F_NBITS-1:0] P =
        {`F_NBITS{1'b1}} - `F_NBITS'(`F_I - 1);

    // A single carry fix-up per fold is enough only when this holds.
    function automatic bit fold_ok(int nbits, int i, int step);
        logic [255:0] lhs;
        logic [255:0] rhs;
        lhs = ((256'd1 << step) + 256'd1) * 256'(i);
        rhs = 256'd1 << nbits;
        return (step >= 1) && (lhs < rhs);
    endfunction

endpackage

// File: rtl/field_fold_step.sv
// One fold of v*2^k back into NBITS bits using 2^NBITS == I (mod p).
// Purely combinational; k never exceeds STEP.
module field_fold_step
    import field_pow2_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int I     = 5,
    parameter int STEP  = 4,
    parameter int KW    = 3
) (
    input  logic [NBITS-1:0] v,
    input  logic [KW-1:0]    k,
    output logic [NBITS-1:0] v_nxt
);

    logic [NBITS+STEP-1:0] t;
    logic [NBITS:0]        w;

    always_comb begin
        t = {{STEP{1'b0}}, v} << k;
        w = {1'b0, t[NBITS-1:0]}
          + (NBITS+1)'(t[NBITS+STEP-1:NBITS]) * (NBITS+1)'(I);
        v_nxt = w[NBITS] ? w[NBITS-1:0] + NBITS'(I)
                         : w[NBITS-1:0];
    end

endmodule

// File: rtl/field_mul_pow2.sv
// c = a * 2^s mod (2^NBITS - I), folding up to STEP bits per cycle.
// Optional negation of the result with FIELD_MUL_POW2_NEG_EN.
module field_mul_pow2
    import field_pow2_pkg::*;
#(
    parameter int NBITS   = `F_NBITS,
    parameter int I       = `F_I,
    parameter int STEP    = 4,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [NBITS-1:0]   a,
    input  logic [SHIFT_W-1:0] s,
`ifdef FIELD_MUL_POW2_NEG_EN
    input  logic               neg,
`endif
    output logic               ready_pulse,
    output logic               ready,
    output logic [NBITS-1:0]   c
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [NBITS-1:0] PL =
        {NBITS{1'b1}} - NBITS'(I - 1);
    localparam logic [SHIFT_W-1:0] STEP_S = SHIFT_W'(STEP);

    generate
        if (!fold_ok(NBITS, I, STEP)) begin : g_bad_cfg
            $error("field_mul_pow2: (2^STEP+1)*I must be < 2^NBITS");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic [NBITS-1:0]   v;
    logic [NBITS-1:0]   v_fold;
    logic [SHIFT_W-1:0] rem;
    logic [KW-1:0]      k;
    logic [NBITS-1:0]   r;
    logic [NBITS-1:0]   res;
`ifdef FIELD_MUL_POW2_NEG_EN
    logic               neg_q;
`endif

    field_fold_step #(
        .NBITS(NBITS),
        .I    (I),
        .STEP (STEP),
        .KW   (KW)
    ) u_fold (
        .v    (v),
        .k    (k),
        .v_nxt(v_fold)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        k = (rem > STEP_S) ? KW'(STEP) : KW'(rem);
        unique case (state)
            IDLE: begin
                if (en) begin
                    load      = 1'b1;
                    state_nxt = (s == '0) ? REDUCE : FOLD;
                end
            end
            FOLD: begin
                if (rem <= STEP_S)
                    state_nxt = REDUCE;
            end
            REDUCE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // v + I wraps past 2^NBITS exactly when v is in [p, 2^NBITS).
    always_comb begin
        r   = (v >= PL) ? v + NBITS'(I) : v;
        res = r;
`ifdef FIELD_MUL_POW2_NEG_EN
        if (neg_q && (r != '0))
            res = PL - r;
`endif
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            v           <= '0;
            rem         <= '0;
            c           <= '0;
            ready_pulse <= 1'b0;
`ifdef FIELD_MUL_POW2_NEG_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            ready_pulse <= 1'b0;
            if (load) begin
                v   <= a;
                rem <= s;
`ifdef FIELD_MUL_POW2_NEG_EN
                neg_q <= neg;
`endif
            end
            if (state == FOLD) begin
                v   <= v_fold;
                rem <= rem - SHIFT_W'(k);
            end
            if (state == REDUCE) begin
                c           <= res;
                ready_pulse <= 1'b1;
            end
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_field_mul_pow2.sv
// Self-checking bench for field_mul_pow2 (p = 251, STEP = 2).
// Build with FIELD_MUL_POW2_NEG_EN to exercise negation.
module tb_field_mul_pow2;

    localparam int NB = 8;
    localparam int IC = 5;
    localparam int ST = 2;
    localparam int SW = 4;
    localparam int PR = 251;

    logic          clk  = 1'b0;
    logic          rstb = 1'b0;
    logic          en   = 1'b0;
    logic [NB-1:0] a    = '0;
    logic [SW-1:0] s    = '0;
    logic          neg  = 1'b0;
    logic          ready_pulse;
    logic          ready;
    logic [NB-1:0] c;

    always #5 clk = ~clk;

    field_mul_pow2 #(
        .NBITS  (NB),
        .I      (IC),
        .STEP   (ST),
        .SHIFT_W(SW)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .en         (en),
        .a          (a),
        .s          (s),
`ifdef FIELD_MUL_POW2_NEG_EN
        .neg        (neg),
`endif
        .ready_pulse(ready_pulse),
        .ready      (ready),
        .c          (c)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_c = 0;
    int exp_q[$];
    int due_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int golden(int av, int sv, bit nv);
        int x;
        x = av % PR;
        repeat (sv) x = (x * 2) % PR;
        if (nv && x != 0) x = PR - x;
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int e;
        int d;
        if (!rstb) begin
            last_c = 0;
        end else if (ready_pulse) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                chk("result", int'(c), e);
                chk("latency", cyc, d);
                chk("ready_at_pulse", int'(ready), 1);
            end
            last_c = int'(c);
        end else begin
            chk("c_stable", int'(c), last_c);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(int av, int sv, bit nv);
        en  = 1'b1;
        a   = NB'(av);
        s   = SW'(sv);
        neg = nv;
        exp_q.push_back(golden(av, sv, nv));
        due_q.push_back(cyc + 2 + (sv + ST - 1) / ST);
        step();
        en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0) begin
            chk("timeout", exp_q.size(), 0);
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic run(int av, int sv, bit nv, int lit);
        issue(av, sv, nv);
        wait_idle();
        chk("literal", int'(c), lit);
    endtask

    initial begin
        int av;
        bit nv;
        int k;
        step();
        step();
        chk("rst_ready", int'(ready), 1);
        chk("rst_pulse", int'(ready_pulse), 0);
        chk("rst_c", int'(c), 0);
        rstb = 1'b1;
        step();

        issue(200, 1, 1'b0);
        chk("busy_ready0", int'(ready), 0);
        chk("busy_pulse0", int'(ready_pulse), 0);
        step();
        chk("busy_ready1", int'(ready), 0);
        step();
        chk("done_pulse", int'(ready_pulse), 1);
        chk("done_ready", int'(ready), 1);
        chk("c_149", int'(c), 149);
        wait_idle();

        run(3, 7, 1'b0, 133);
        run(255, 0, 1'b0, 4);
        run(250, 0, 1'b0, 250);
        run(0, 15, 1'b0, 0);

        issue(3, 7, 1'b0);
        en = 1'b1;
        a  = 8'd77;
        s  = 4'd0;
        step();
        en = 1'b0;
        wait_idle();
        chk("ignore_en", int'(c), 133);

        issue(200, 1, 1'b0);
        k = 0;
        while (!ready_pulse && k < 20) begin
            step();
            k++;
        end
        chk("b2b_seen", int'(ready_pulse), 1);
        issue(1, 5, 1'b0);
        wait_idle();
        chk("b2b_c", int'(c), 32);

        issue(3, 7, 1'b0);
        step();
        #2 rstb = 1'b0;
        #1;
        chk("arst_ready", int'(ready), 1);
        chk("arst_c", int'(c), 0);
        exp_q.delete();
        due_q.delete();
        step();
        step();
        rstb = 1'b1;
        for (int i = 0; i < 8; i++) step();
        run(200, 1, 1'b0, 149);

`ifdef FIELD_MUL_POW2_NEG_EN
        run(1, 3, 1'b1, 243);
        run(0, 5, 1'b1, 0);
        run(251, 0, 1'b1, 0);
`endif

        for (int sv = 0; sv < 16; sv++) begin
            av = int'($urandom_range(0, 255));
`ifdef FIELD_MUL_POW2_NEG_EN
            nv = 1'($urandom_range(0, 1));
`else
            nv = 1'b0;
`endif
            issue(av, sv, nv);
            wait_idle();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got 0 want 1");
        $fatal(1, "watchdog");
    end

endmodule
